// File: rtl/si_aliens_timebase.sv
// Timebase for the aliens control FSM: move tick, transition tick, 4-phase
// move pattern and level code, all driven from the FSM's active-low controls.
module si_aliens_timebase #(
  parameter int          CNT_W          = 27,
  parameter int unsigned MOVE_PERIOD_L1 = 25000000,
  parameter int unsigned MOVE_PERIOD_L2 = 12500000,
  parameter int unsigned MOVE_PERIOD_L3 = 6250000,
  parameter int unsigned TRANS_PERIOD   = 100000000
) (
  input  logic       SI_STATEMACHINE_ALIENS_CLOCK_50,
  input  logic       SI_STATEMACHINE_ALIENS_RESET_InLow,
  input  logic       SI_ALIENS_TIMEBASE_ENABLE_COUNTMA_InLow,
  input  logic       SI_ALIENS_TIMEBASE_ENABLE_COUNTRA_InLow,
  input  logic       SI_ALIENS_TIMEBASE_COUNTUP_COUNT4MA_InLow,
  input  logic       SI_ALIENS_TIMEBASE_CLEARCOUNT_COUNT4MA_InLow,
  input  logic       SI_ALIENS_TIMEBASE_LOAD_InLow,
  input  logic [2:0] SI_ALIENS_TIMEBASE_TRANSITION_BUS,
  input  logic [2:0] SI_ALIENS_TIMEBASE_SELECT_4MUX21,
  output logic       SI_ALIENS_TIMEBASE_COUNTMA_OutLow,
  output logic       SI_ALIENS_TIMEBASE_COUNTRA_OutLow,
  output logic [1:0] SI_ALIENS_TIMEBASE_COUNT4MA_OutLow,
  output logic [1:0] SI_ALIENS_TIMEBASE_COUNTLEVEL_OutLow
);

  localparam logic [CNT_W-1:0] MA_TOP_L1 = CNT_W'(MOVE_PERIOD_L1 - 1);
  localparam logic [CNT_W-1:0] MA_TOP_L2 = CNT_W'(MOVE_PERIOD_L2 - 1);
  localparam logic [CNT_W-1:0] MA_TOP_L3 = CNT_W'(MOVE_PERIOD_L3 - 1);
  localparam logic [CNT_W-1:0] RA_TOP    = CNT_W'(TRANS_PERIOD - 1);

  logic [1:0]       lvl_reg, lvl_next;
  logic [CNT_W-1:0] cma_reg, cma_next;
  logic [CNT_W-1:0] cra_reg, cra_next;
  logic [CNT_W-1:0] ma_top;
  logic             ma_n_reg, ma_n_next;
  logic             ra_n_reg, ra_n_next;
  logic [1:0]       phase_reg, phase_next;
  logic [1:0]       code_reg, code_next;

  always_comb begin
    lvl_next = lvl_reg;
    if (!SI_ALIENS_TIMEBASE_LOAD_InLow &&
        SI_ALIENS_TIMEBASE_TRANSITION_BUS == 3'b001 &&
        SI_ALIENS_TIMEBASE_SELECT_4MUX21 == 3'b000)
      lvl_next = 2'b00;
    else if (SI_ALIENS_TIMEBASE_SELECT_4MUX21 == 3'b011)
      lvl_next = 2'b01;
    else if (SI_ALIENS_TIMEBASE_SELECT_4MUX21 == 3'b100)
      lvl_next = 2'b10;
  end

  always_comb begin
    case (lvl_reg)
      2'b01:   ma_top = MA_TOP_L2;
      2'b10:   ma_top = MA_TOP_L3;
      default: ma_top = MA_TOP_L1;
    endcase
  end

  // The move tick is held (counter frozen) until COUNTUP consumes it.
  // ">=" rather than "==" lets a level change to a shorter period wrap cleanly.
  always_comb begin
    cma_next  = cma_reg;
    ma_n_next = ma_n_reg;
    if (SI_ALIENS_TIMEBASE_ENABLE_COUNTMA_InLow ||
        !SI_ALIENS_TIMEBASE_COUNTUP_COUNT4MA_InLow) begin
      cma_next  = '0;
      ma_n_next = 1'b1;
    end else if (ma_n_reg) begin
      if (cma_reg >= ma_top) begin
        cma_next  = '0;
        ma_n_next = 1'b0;
      end else begin
        cma_next = cma_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    phase_next = phase_reg;
    if (!SI_ALIENS_TIMEBASE_CLEARCOUNT_COUNT4MA_InLow)
      phase_next = 2'd0;
    else if (!SI_ALIENS_TIMEBASE_COUNTUP_COUNT4MA_InLow)
      phase_next = phase_reg + 2'd1;
    case (phase_next)
      2'd0:    code_next = 2'b01;
      2'd2:    code_next = 2'b10;
      default: code_next = 2'b00;
    endcase
  end

  always_comb begin
    cra_next  = '0;
    ra_n_next = 1'b1;
    if (!SI_ALIENS_TIMEBASE_ENABLE_COUNTRA_InLow) begin
      if (cra_reg == RA_TOP)
        ra_n_next = 1'b0;
      else
        cra_next = cra_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge SI_STATEMACHINE_ALIENS_CLOCK_50 or negedge SI_STATEMACHINE_ALIENS_RESET_InLow) begin
    if (!SI_STATEMACHINE_ALIENS_RESET_InLow) begin
      lvl_reg   <= 2'b00;
      cma_reg   <= '0;
      cra_reg   <= '0;
      ma_n_reg  <= 1'b1;
      ra_n_reg  <= 1'b1;
      phase_reg <= 2'd0;
      code_reg  <= 2'b01;
    end else begin
      lvl_reg   <= lvl_next;
      cma_reg   <= cma_next;
      cra_reg   <= cra_next;
      ma_n_reg  <= ma_n_next;
      ra_n_reg  <= ra_n_next;
      phase_reg <= phase_next;
      code_reg  <= code_next;
    end
  end

  assign SI_ALIENS_TIMEBASE_COUNTMA_OutLow    = ma_n_reg;
  assign SI_ALIENS_TIMEBASE_COUNTRA_OutLow    = ra_n_reg;
  assign SI_ALIENS_TIMEBASE_COUNT4MA_OutLow   = code_reg;
  assign SI_ALIENS_TIMEBASE_COUNTLEVEL_OutLow = lvl_reg;

endmodule

// File: tb/tb_si_aliens_timebase.sv
// Self-checking bench for si_aliens_timebase with small periods (8/4/2, 5)
// and an edge-counting reference model.
module tb_si_aliens_timebase;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_ma_n, en_ra_n, cu_n, clr_n, load_n;
  logic [2:0] tbus, sel;
  logic       ma, ra;
  logic [1:0] c4, lv;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt, m_rcnt, m_phase, m_lvl;
  bit m_pend, m_rpulse;
  localparam logic [1:0] PH_CODE [4] = '{2'b01, 2'b00, 2'b10, 2'b00};

  si_aliens_timebase #(
    .CNT_W(8), .MOVE_PERIOD_L1(8), .MOVE_PERIOD_L2(4),
    .MOVE_PERIOD_L3(2), .TRANS_PERIOD(5)
  ) dut (
    .SI_STATEMACHINE_ALIENS_CLOCK_50             (clk),
    .SI_STATEMACHINE_ALIENS_RESET_InLow          (rst_n),
    .SI_ALIENS_TIMEBASE_ENABLE_COUNTMA_InLow     (en_ma_n),
    .SI_ALIENS_TIMEBASE_ENABLE_COUNTRA_InLow     (en_ra_n),
    .SI_ALIENS_TIMEBASE_COUNTUP_COUNT4MA_InLow   (cu_n),
    .SI_ALIENS_TIMEBASE_CLEARCOUNT_COUNT4MA_InLow(clr_n),
    .SI_ALIENS_TIMEBASE_LOAD_InLow               (load_n),
    .SI_ALIENS_TIMEBASE_TRANSITION_BUS           (tbus),
    .SI_ALIENS_TIMEBASE_SELECT_4MUX21            (sel),
    .SI_ALIENS_TIMEBASE_COUNTMA_OutLow           (ma),
    .SI_ALIENS_TIMEBASE_COUNTRA_OutLow           (ra),
    .SI_ALIENS_TIMEBASE_COUNT4MA_OutLow          (c4),
    .SI_ALIENS_TIMEBASE_COUNTLEVEL_OutLow        (lv)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_rcnt = 0; m_phase = 0; m_lvl = 0; m_pend = 0; m_rpulse = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_update();
    int period;
    if (!rst_n) begin
      model_reset();
      return;
    end
    period = (m_lvl == 0) ? 8 : (m_lvl == 1) ? 4 : 2;
    if (en_ma_n || !cu_n) begin
      m_cnt = 0; m_pend = 0;
    end else if (!m_pend) begin
      m_cnt++;
      if (m_cnt >= period) begin m_cnt = 0; m_pend = 1; end
    end
    if (!clr_n) m_phase = 0;
    else if (!cu_n) m_phase = (m_phase + 1) % 4;
    if (!load_n && tbus == 3'b001 && sel == 3'b000) m_lvl = 0;
    else if (sel == 3'b011) m_lvl = 1;
    else if (sel == 3'b100) m_lvl = 2;
    if (en_ra_n) begin
      m_rcnt = 0; m_rpulse = 0;
    end else begin
      m_rcnt++;
      m_rpulse = (m_rcnt == 5);
      if (m_rpulse) m_rcnt = 0;
    end
  endtask

  function automatic logic [5:0] exp_outs();
    return {~m_pend, ~m_rpulse, PH_CODE[m_phase], 2'(m_lvl)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    en_ma_n = 1; en_ra_n = 1; cu_n = 1; clr_n = 1; load_n = 1; tbus = 3'b000; sel = 3'b000;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    en_ma_n = 0; en_ra_n = 0; cu_n = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) cu_n = 1;
      tick();
      obs = {ma, ra, c4, lv};
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL reset_pre cyc=%0d got=%b exp=%b", i, obs, exp_outs());
      end
    end
    #2 rst_n = 0;
    #1;
    obs = {ma, ra, c4, lv};
    checks++;
    if (obs !== 6'b110100) begin
      errors++; $display("FAIL reset_async got=%b exp=%b", obs, 6'b110100);
    end
    model_reset();
    idle_inputs();
    tick();
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      obs = {ma, ra, c4, lv};
      checks++;
      if (obs !== 6'b110100) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, 6'b110100);
      end
    end
  endtask

  task automatic test_move_tick();
    logic [5:0] obs;
    int n;
    en_ma_n = 0;
    n = 0;
    do begin
      tick(); n++;
      obs = {ma, ra, c4, lv};
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL move_run cyc=%0d got=%b exp=%b", n, obs, exp_outs());
      end
    end while (ma !== 1'b0 && n < 40);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL move_first_tick edges got=%0d exp=8", n); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ma !== 1'b0) begin errors++; $display("FAIL move_hold cyc=%0d got=%b exp=0", i, ma); end
    end
    cu_n = 0;
    tick();
    cu_n = 1;
    obs = {ma, ra, c4, lv};
    checks++;
    if ({ma, c4} !== 3'b100 || obs !== exp_outs()) begin
      errors++; $display("FAIL move_consume got=%b exp=%b", obs, exp_outs());
    end
    n = 0;
    do begin tick(); n++; end while (ma !== 1'b0 && n < 40);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL move_next_tick edges got=%0d exp=8", n); end
  endtask

  task automatic test_phase_seq();
    logic [1:0] seq [5];
    logic [1:0] exp_seq [5];
    int n;
    exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    clr_n = 0; cu_n = 0;
    tick();
    clr_n = 1; cu_n = 1;
    seq[0] = c4;
    for (int k = 1; k < 5; k++) begin
      n = 0;
      while (ma !== 1'b0 && n < 40) begin
        tick(); n++;
        checks++;
        if ({ma, ra, c4, lv} !== exp_outs()) begin
          errors++; $display("FAIL phase_wait k=%0d got=%b exp=%b", k, {ma, ra, c4, lv}, exp_outs());
        end
      end
      cu_n = 0;
      tick();
      cu_n = 1;
      seq[k] = c4;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (seq[k] !== exp_seq[k]) begin
        errors++; $display("FAIL phase_seq step=%0d got=%b exp=%b", k, seq[k], exp_seq[k]);
      end
    end
    cu_n = 0;
    tick();
    clr_n = 0;
    tick();
    clr_n = 1; cu_n = 1;
    checks++;
    if (c4 !== 2'b01 || c4 !== PH_CODE[m_phase]) begin
      errors++; $display("FAIL phase_clear_prio got=%b exp=01", c4);
    end
  endtask

  task automatic test_transition();
    logic [15:0] mask;
    int n;
    idle_inputs();
    tick();
    en_ra_n = 0;
    mask = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ra === 1'b0) mask[i] = 1'b1;
      checks++;
      if (ra !== ~m_rpulse) begin errors++; $display("FAIL trans_run edge=%0d got=%b exp=%b", i, ra, ~m_rpulse); end
    end
    checks++;
    if (mask !== 16'h0420) begin errors++; $display("FAIL trans_pulses got=%h exp=0420", mask); end
    en_ra_n = 1;
    tick();
    en_ra_n = 0;
    repeat (6) tick();
    en_ra_n = 1;
    tick();
    en_ra_n = 0;
    n = 0;
    do begin tick(); n++; end while (ra !== 1'b0 && n < 40);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL trans_restart edges got=%0d exp=5", n); end
    tick();
    checks++;
    if (ra !== 1'b1) begin errors++; $display("FAIL trans_one_cycle got=%b exp=1", ra); end
    en_ra_n = 1;
  endtask

  task automatic test_levels();
    int n;
    int exp_p [3];
    logic [2:0] sels [3];
    exp_p = '{4, 4, 2};
    sels = '{3'b011, 3'b011, 3'b100};
    for (int k = 0; k < 3; k++) begin
      sel = sels[k];
      tick();
      sel = 3'b000;
      checks++;
      if (lv !== 2'(m_lvl) || lv !== (k == 2 ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL level_code k=%0d got=%b exp=%b", k, lv, 2'(m_lvl));
      end
      en_ma_n = 1;
      tick();
      en_ma_n = 0;
      n = 0;
      do begin tick(); n++; end while (ma !== 1'b0 && n < 40);
      checks++;
      if (n !== exp_p[k]) begin errors++; $display("FAIL level_period k=%0d got=%0d exp=%0d", k, n, exp_p[k]); end
      cu_n = 0;
      tick();
      cu_n = 1;
    end
    load_n = 0; tbus = 3'b001; sel = 3'b000;
    tick();
    load_n = 1; tbus = 3'b000;
    checks++;
    if (lv !== 2'b00) begin errors++; $display("FAIL level_init got=%b exp=00", lv); end
  endtask

  task automatic test_pending_disable();
    int n;
    en_ma_n = 1;
    tick();
    en_ma_n = 0;
    n = 0;
    do begin tick(); n++; end while (ma !== 1'b0 && n < 40);
    en_ma_n = 1;
    tick();
    checks++;
    if (ma !== 1'b1) begin errors++; $display("FAIL pend_disable got=%b exp=1", ma); end
    en_ma_n = 0;
    n = 0;
    do begin tick(); n++; end while (ma !== 1'b0 && n < 40);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL pend_restart edges got=%0d exp=8", n); end
    en_ma_n = 1;
    tick();
  endtask

  task automatic test_random();
    logic [5:0] obs;
    int r;
    for (int i = 0; i < 400; i++) begin
      en_ma_n = ($urandom_range(7) == 0);
      en_ra_n = ($urandom_range(5) == 0);
      cu_n    = (ma === 1'b0) ? ($urandom_range(2) != 0) : ($urandom_range(15) != 0);
      clr_n   = ($urandom_range(19) != 0);
      load_n  = ($urandom_range(1) != 0);
      tbus    = ($urandom_range(1) != 0) ? 3'b001 : 3'($urandom);
      r = $urandom_range(19);
      sel = (r == 0) ? 3'b011 : (r == 1) ? 3'b100 : (r == 2) ? 3'($urandom) : 3'b000;
      tick();
      obs = {ma, ra, c4, lv};
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, exp_outs());
      end
    end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    tick();
    tick();
    rst_n = 1;
    test_reset();
    test_move_tick();
    test_phase_seq();
    test_transition();
    test_levels();
    test_pending_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/si_aliens_timebase.md
Name: si_aliens_timebase

Overview:
- Timing and sequencing datapath that answers the aliens control FSM. It turns the FSM's active-low counter controls into the status inputs that FSM consumes.
- Generates:
  - the alien move tick (COUNTMA)
  - the transition/screen delay tick (COUNTRA)
  - the 4-phase move pattern (COUNT4MA: right, down, left, down)
  - the current level code (COUNTLEVEL)
- Sits between the aliens FSM and the 50 MHz clock domain. All outputs are registered.

Parameters:
- CNT_W, 27, width of both period counters.
- MOVE_PERIOD_L1, 25000000, move-tick period in clocks, level 1 (code 00); must be >= 2.
- MOVE_PERIOD_L2, 12500000, move-tick period, level 2 (code 01).
- MOVE_PERIOD_L3, 6250000, move-tick period, level 3 (code 10).
- TRANS_PERIOD, 100000000, transition-tick period in clocks; must be >= 2.

Ports:
- SI_STATEMACHINE_ALIENS_CLOCK_50  in  1  system clock, rising edge.
- SI_STATEMACHINE_ALIENS_RESET_InLow  in  1  reset, asynchronous, active-low.
- SI_ALIENS_TIMEBASE_ENABLE_COUNTMA_InLow  in  1  0 = run move-period counter.
- SI_ALIENS_TIMEBASE_ENABLE_COUNTRA_InLow  in  1  0 = run transition counter.
- SI_ALIENS_TIMEBASE_COUNTUP_COUNT4MA_InLow  in  1  0 = advance phase and consume move tick.
- SI_ALIENS_TIMEBASE_CLEARCOUNT_COUNT4MA_InLow  in  1  0 = phase back to 0.
- SI_ALIENS_TIMEBASE_LOAD_InLow  in  1  FSM load strobe, used for level decode.
- SI_ALIENS_TIMEBASE_TRANSITION_BUS  in  3  FSM screen code, used for level decode.
- SI_ALIENS_TIMEBASE_SELECT_4MUX21  in  3  FSM mux select, used for level decode.
- SI_ALIENS_TIMEBASE_COUNTMA_OutLow  out  1  0 = move tick pending.
- SI_ALIENS_TIMEBASE_COUNTRA_OutLow  out  1  0 = transition tick (one-cycle pulse).
- SI_ALIENS_TIMEBASE_COUNT4MA_OutLow  out  2  phase code: 01 right, 00 down, 10 left.
- SI_ALIENS_TIMEBASE_COUNTLEVEL_OutLow  out  2  level code: 00 L1, 01 L2, 10 L3.

Behaviour:

Reset and clocking:
- Reset is asynchronous and active-low. All state updates on the rising edge of CLOCK_50.
- Reset values:
  - COUNTMA_OutLow = 1, COUNTRA_OutLow = 1.
  - COUNT4MA_OutLow = 01 (phase 0).
  - COUNTLEVEL_OutLow = 00.
  - Both counters = 0, pending = 0.
- Reset mid-operation discards every count and pending tick immediately.

Level register (lvl):
- Init decode: LOAD_InLow = 0 and TRANSITION_BUS = 001 and SELECT_4MUX21 = 000 → lvl <= 00.
- SELECT_4MUX21 = 011 → lvl <= 01.
- SELECT_4MUX21 = 100 → lvl <= 10.
- Any other input combination holds lvl.
- The code 11 is never produced.
- Priority when decodes overlap: Init decode > 011 > 100.

Move counter (cma, pending):
- Active period P = MOVE_PERIOD for the current lvl.
- ENABLE_COUNTMA = 1: cma <= 0, pending <= 0.
- ENABLE_COUNTMA = 0 and pending = 0:
  - if cma == P-1: cma <= 0, pending <= 1.
  - else: cma <= cma + 1.
- While pending = 1, cma halts.
- COUNTUP = 0 clears pending. In the same cycle, cma restarts from 0 on the following edge.
- COUNTMA_OutLow = ~pending.
  - First tick is visible after the P-th enabled edge.
  - The tick stays low until consumed, so it is not lost while the FSM services a bullet Load.
- If lvl changes while cma > new P-1 (should not happen in normal flow), the counter wraps: cma <= 0, pending <= 1 on the next enabled edge.

Phase counter (s, 2 bits):
- CLEARCOUNT = 0 → s <= 0. This has priority over COUNTUP.
- COUNTUP = 0 → s <= s + 1, wrapping 3 → 0.
- COUNT4MA_OutLow decode: s0 → 01, s1 → 00, s2 → 10, s3 → 00.
- Each COUNTUP low cycle advances exactly one step. A held COUNTUP advances once per cycle.

Transition counter (cra, pulse):
- ENABLE_COUNTRA = 1: cra <= 0, pulse <= 0.
- ENABLE_COUNTRA = 0:
  - if cra == TRANS_PERIOD-1: cra <= 0, pulse <= 1.
  - else: cra <= cra + 1, pulse <= 0.
- COUNTRA_OutLow = ~pulse.
- Result: a one-cycle low pulse every TRANS_PERIOD enabled clocks. Repeats if the enable stays low.

Arithmetic:
- Counters are unsigned CNT_W bits. All period parameters must be < 2^CNT_W.

Test Plan:
Parameters for all scenarios: L1 = 8, L2 = 4, L3 = 2, TRANS = 5.
1. Reset low mid-count → all outputs at reset values within the same cycle. Release, hold all inputs idle (1, buses 000) → outputs unchanged for 20 cycles.
2. ENABLE_COUNTMA = 0 at lvl 00 → COUNTMA_OutLow goes 0 after edge 8 and stays 0 for 5 idle cycles. COUNTUP low one cycle → COUNTMA returns 1, COUNT4MA 01 → 00, next tick 8 edges later.
3. Four consumed ticks → COUNT4MA sequence 01, 00, 10, 00, 01. CLEARCOUNT and COUNTUP low together → COUNT4MA = 01.
4. ENABLE_COUNTRA = 0 for 12 cycles → COUNTRA low exactly at edges 5 and 10, one cycle each. Enable high at edge 7 → counter restarts from 0.
5. SELECT_4MUX21 = 011 → COUNTLEVEL 01, move tick every 4 clocks. Then 100 → COUNTLEVEL 10, tick every 2. Then Init decode (LOAD 0, TRANS 001, SEL 000) → COUNTLEVEL 00.
6. Tick pending while ENABLE_COUNTMA goes 1 → COUNTMA_OutLow = 1 next cycle, cma = 0.
